// File: rtl/sid_bus_master.sv
// SID register-port bus initiator: a command FIFO feeding a bus FSM that issues
// one-cycle write/read accesses and timed waits, returning read data from sid_do.
module sid_bus_master #(
   parameter int FIFO_DEPTH = 8,
   parameter int WAIT_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  cmd_op,
   input  logic [4:0]                  cmd_addr,
   input  logic [WAIT_W-1:0]           cmd_arg,
   output logic                        rd_valid,
   output logic [7:0]                  rd_data,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        sid_cs,
   output logic                        sid_rw,
   output logic [4:0]                  sid_a,
   output logic [7:0]                  sid_di,
   input  logic [7:0]                  sid_do
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_WAIT  = 2'd2,
      OP_NOP   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_WAIT
   } state_e;

   typedef struct packed {
      op_e               op;
      logic [4:0]        addr;
      logic [WAIT_W-1:0] arg;
   } entry_t;

   entry_t             fifo_mem [FIFO_DEPTH];
   entry_t             head;

   state_e             state_q,    state_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [LVL_W-1:0]   level_q,    level_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               sid_cs_q,   sid_cs_d;
   logic               sid_rw_q,   sid_rw_d;
   logic [4:0]         sid_a_q,    sid_a_d;
   logic [7:0]         sid_di_q,   sid_di_d;
   logic               rd_valid_q, rd_valid_d;
   logic [7:0]         rd_data_q,  rd_data_d;

   logic               push;
   logic               pop;

   assign cmd_ready = (level_q != LVL_W'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_IDLE) && (level_q != '0);
   assign head      = fifo_mem[rd_ptr_q];

   // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      wait_cnt_d = wait_cnt_q;
      sid_cs_d   = sid_cs_q;
      sid_rw_d   = sid_rw_q;
      sid_a_d    = sid_a_q;
      sid_di_d   = sid_di_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               case (head.op)
                  OP_WRITE: begin
                     state_d  = S_WRITE;
                     sid_a_d  = head.addr;
                     sid_di_d = head.arg[7:0];
                     sid_cs_d = 1'b1;
                     sid_rw_d = 1'b1;
                  end
                  OP_READ: begin
                     state_d  = S_READ;
                     sid_a_d  = head.addr;
                     sid_cs_d = 1'b1;
                     sid_rw_d = 1'b0;
                  end
                  // A zero wait is stretched to one cycle so WAIT is never skipped.
                  OP_WAIT: begin
                     state_d    = S_WAIT;
                     wait_cnt_d = (head.arg == '0) ? '0 : head.arg - WAIT_W'(1);
                  end
                  OP_NOP: begin
                     state_d = S_IDLE;
                  end
               endcase
            end
         end
         S_WRITE: begin
            state_d  = S_IDLE;
            sid_cs_d = 1'b0;
            sid_rw_d = 1'b0;
         end
         S_READ: begin
            state_d    = S_IDLE;
            sid_cs_d   = 1'b0;
            sid_rw_d   = 1'b0;
            rd_data_d  = sid_do;
            rd_valid_d = 1'b1;
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) state_d = S_IDLE;
            else                  wait_cnt_d = wait_cnt_q - WAIT_W'(1);
         end
      endcase
   end

   // NOTE: clocked blocks use only non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         wait_cnt_q <= '0;
         sid_cs_q   <= 1'b0;
         sid_rw_q   <= 1'b0;
         sid_a_q    <= '0;
         sid_di_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         wait_cnt_q <= wait_cnt_d;
         sid_cs_q   <= sid_cs_d;
         sid_rw_q   <= sid_rw_d;
         sid_a_q    <= sid_a_d;
         sid_di_q   <= sid_di_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and level alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= entry_t'({cmd_op, cmd_addr, cmd_arg});
   end

   assign busy     = (state_q != S_IDLE) || (level_q != '0);
   assign level    = level_q;
   assign sid_cs   = sid_cs_q;
   assign sid_rw   = sid_rw_q;
   assign sid_a    = sid_a_q;
   assign sid_di   = sid_di_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule
